// File: rtl/gl6_pkg.sv
// ============================================================================
// gl6_pkg : shared types and helpers for the gl6 2x2 upscaler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package gl6_pkg;

  typedef enum logic [0:0] {
    ST_PASS   = 1'b0,
    ST_REPLAY = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    COPY0 = 1'b0,
    COPY1 = 1'b1
  } copy_e;

  // Counters must represent 0..MAX_LINE inclusive.
  function automatic int cnt_width(input int max_line);
    return $clog2(max_line + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gl6_line_ram.sv
// ============================================================================
// gl6_line_ram : simple dual-port line buffer, one write port and one
//                read port with a 1-cycle registered read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gl6_line_ram #(
  parameter int D_WIDTH = 8,
  parameter int DEPTH   = 1024,
  parameter int AW      = 10
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [D_WIDTH-1:0] wdata_i,
  input  logic               re_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [D_WIDTH-1:0] rdata_o
);

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [D_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    // Read data holds when not re-read, keeping replay beats stable in stalls.
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/gl6_upscale_2x2.sv
// ============================================================================
// gl6_upscale_2x2 : streaming 2x2 pixel upscaler (pixel doubled, line replayed).
//                   GL6_UPSCALE_LINE_REPEAT_EN enables line replay; without it
//                   the block is a horizontal-only 2x1 upscaler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gl6_upscale_2x2 #(
  parameter int D_WIDTH  = 8,
  parameter int MAX_LINE = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  input  logic               up_tlast,
  input  logic               up_tuser,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  output logic               down_tlast,
  output logic               down_tuser,
  input  logic               down_ready
);

  import gl6_pkg::*;

  logic               hold_valid_q, hold_valid_d;
  copy_e              hold_copy_q,  hold_copy_d;
  logic [D_WIDTH-1:0] hold_data_q,  hold_data_d;
  logic               hold_last_q,  hold_last_d;
  logic               hold_user_q,  hold_user_d;

  logic pass_st;
  logic in_acc;
  logic hold_acc;

`ifdef GL6_UPSCALE_LINE_REPEAT_EN
  localparam int            CW      = cnt_width(MAX_LINE);
  localparam int            AW      = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
  localparam logic [CW-1:0] MAX_IDX = CW'(MAX_LINE);

  state_e              state_q,    state_d;
  logic [CW-1:0]       wr_idx_q,   wr_idx_d;
  logic [CW-1:0]       line_len_q, line_len_d;
  logic [CW-1:0]       rd_idx_q,   rd_idx_d;
  logic                rep_valid_q, rep_valid_d;
  copy_e               rep_copy_q,  rep_copy_d;
  logic                rep_last_q,  rep_last_d;
  logic                ram_we;
  logic                ram_re;
  logic [D_WIDTH-1:0]  ram_rdata;
  logic                tlast_done;
  logic                rep_acc;
  logic                need_load;

  assign pass_st = (state_q == ST_PASS);
`else
  assign pass_st = 1'b1;
`endif

  assign up_ready = !rst && pass_st &&
                    (!hold_valid_q ||
                     (hold_copy_q == COPY1 && down_ready && !hold_last_q));
  assign in_acc   = up_valid && up_ready;
  assign hold_acc = pass_st && hold_valid_q && down_ready;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_copy_d  = hold_copy_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_user_d  = hold_user_q;
    if (in_acc) begin
      hold_valid_d = 1'b1;
      hold_copy_d  = COPY0;
      hold_data_d  = up_data;
      hold_last_d  = up_tlast;
      hold_user_d  = up_tuser;
    end else if (hold_acc) begin
      if (hold_copy_q == COPY0) begin
        hold_copy_d = COPY1;
      end else begin
        hold_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_copy_q  <= COPY0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_user_q  <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_copy_q  <= hold_copy_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_user_q  <= hold_user_d;
    end
  end

`ifdef GL6_UPSCALE_LINE_REPEAT_EN
  assign tlast_done = hold_acc && hold_copy_q == COPY1 && hold_last_q;
  assign rep_acc    = rep_valid_q && down_ready;
  assign need_load  = !rep_valid_q || (rep_acc && rep_copy_q == COPY1);

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    line_len_d  = line_len_q;
    rd_idx_d    = rd_idx_q;
    rep_valid_d = rep_valid_q;
    rep_copy_d  = rep_copy_q;
    rep_last_d  = rep_last_q;
    ram_re      = 1'b0;
    ram_we      = in_acc && (wr_idx_q < MAX_IDX);

    if (ram_we) begin
      wr_idx_d = wr_idx_q + CW'(1);
    end
    // The index already points past the last stored pixel, i.e. it is the length.
    if (tlast_done) begin
      state_d    = ST_REPLAY;
      line_len_d = wr_idx_q;
      wr_idx_d   = '0;
    end

    if (state_q == ST_REPLAY) begin
      if (rep_acc && rep_copy_q == COPY0) begin
        rep_copy_d = COPY1;
      end
      if (need_load) begin
        if (rep_valid_q && rep_last_q) begin
          state_d     = ST_PASS;
          rep_valid_d = 1'b0;
          rd_idx_d    = '0;
        end else begin
          ram_re      = 1'b1;
          rd_idx_d    = rd_idx_q + CW'(1);
          rep_valid_d = 1'b1;
          rep_copy_d  = COPY0;
          rep_last_d  = (rd_idx_q + CW'(1) == line_len_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PASS;
      wr_idx_q    <= '0;
      line_len_q  <= '0;
      rd_idx_q    <= '0;
      rep_valid_q <= 1'b0;
      rep_copy_q  <= COPY0;
      rep_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      line_len_q  <= line_len_d;
      rd_idx_q    <= rd_idx_d;
      rep_valid_q <= rep_valid_d;
      rep_copy_q  <= rep_copy_d;
      rep_last_q  <= rep_last_d;
    end
  end

  gl6_line_ram #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (MAX_LINE),
    .AW      (AW)
  ) u_line_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_idx_q[AW-1:0]),
    .wdata_i (up_data),
    .re_i    (ram_re),
    .raddr_i (rd_idx_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    if (state_q == ST_REPLAY) begin
      down_valid = rep_valid_q;
      down_data  = ram_rdata;
      down_tlast = rep_valid_q && rep_copy_q == COPY1 && rep_last_q;
      down_tuser = 1'b0;
    end else begin
      down_valid = hold_valid_q;
      down_data  = hold_data_q;
      down_tlast = hold_valid_q && hold_copy_q == COPY1 && hold_last_q;
      down_tuser = hold_valid_q && hold_copy_q == COPY0 && hold_user_q;
    end
  end
`else
  assign down_valid = hold_valid_q;
  assign down_data  = hold_data_q;
  assign down_tlast = hold_valid_q && hold_copy_q == COPY1 && hold_last_q;
  assign down_tuser = hold_valid_q && hold_copy_q == COPY0 && hold_user_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gl6_upscale_2x2.sv
// ============================================================================
// tb_gl6_upscale_2x2 : self-checking bench for the 2x2 upscaler, adapting to
//                      GL6_UPSCALE_LINE_REPEAT_EN. Line buffer depth is 4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gl6_upscale_2x2;

  localparam int DW = 8;
  localparam int ML = 4;
`ifdef GL6_UPSCALE_LINE_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif
  localparam int K = REPEAT ? 2 : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] up_data;
  logic          up_valid, up_tlast, up_tuser, up_ready;
  logic [DW-1:0] down_data;
  logic          down_valid, down_tlast, down_tuser;
  logic          down_ready;

  always #5 clk = ~clk;

  gl6_upscale_2x2 #(.D_WIDTH(DW), .MAX_LINE(ML)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_tlast   (up_tlast),
    .up_tuser   (up_tuser),
    .up_ready   (up_ready),
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_tlast (down_tlast),
    .down_tuser (down_tuser),
    .down_ready (down_ready)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic          u;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         log_q[$];
  logic [DW-1:0] line_buf[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            tl_in   = 0;
  int            tl_out  = 0;
  bit            stall_en = 1'b0;
  bit            ready_force = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Reference model: every accepted pixel yields two beats; with line repeat a
  // tlast pixel also queues the stored line (first ML pixels) doubled again.
  bit            rst_prev = 1'b0, stall_prev = 1'b0, lat_pend = 1'b0, ready_due = 1'b0;
  beat_t         stall_b, eb, ob, nb;
  logic [DW-1:0] lat_d;
  int            rn;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_up_ready", 32'(up_ready), 0);
      if (rst_prev) begin
        chk("rst_down_valid", 32'(down_valid), 0);
        chk("rst_down_tlast", 32'(down_tlast), 0);
        chk("rst_down_tuser", 32'(down_tuser), 0);
        chk("rst_down_data", 32'(down_data), 0);
      end
      exp_q.delete();
      line_buf.delete();
      tl_in = 0; tl_out = 0;
      stall_prev = 0; lat_pend = 0; ready_due = 0;
    end else begin
      if (tl_in * K > tl_out) chk("ready_blocked", 32'(up_ready), 0);
      if (ready_due) chk("ready_rise", 32'(up_ready), 1);
      ready_due = 0;
      if (lat_pend) begin
        chk("lat_valid", 32'(down_valid), 1);
        chk("lat_data", 32'(down_data), 32'(lat_d));
      end
      lat_pend = 0;
      if (stall_prev) begin
        chk("stall_valid", 32'(down_valid), 1);
        chk("stall_data", 32'(down_data), 32'(stall_b.d));
        chk("stall_tlast", 32'(down_tlast), 32'(stall_b.l));
        chk("stall_tuser", 32'(down_tuser), 32'(stall_b.u));
      end
      if (down_valid && down_ready) begin
        ob = {down_data, down_tlast, down_tuser};
        if (exp_q.size() == 0) begin
          chk("extra_beat_queue", 32'(exp_q.size()), 1);
        end else begin
          eb = exp_q.pop_front();
          chk("out_data", 32'(ob.d), 32'(eb.d));
          chk("out_tlast", 32'(ob.l), 32'(eb.l));
          chk("out_tuser", 32'(ob.u), 32'(eb.u));
          if (eb.l) begin
            tl_out++;
            if (tl_out == tl_in * K) ready_due = 1;
          end
        end
        log_q.push_back(ob);
      end
      stall_prev = down_valid && !down_ready;
      stall_b    = {down_data, down_tlast, down_tuser};
      if (up_valid && up_ready) begin
        lat_pend = 1; lat_d = up_data;
        nb = {up_data, 1'b0, up_tuser};     exp_q.push_back(nb);
        nb = {up_data, up_tlast, 1'b0};     exp_q.push_back(nb);
        line_buf.push_back(up_data);
        if (up_tlast) begin
          tl_in++;
          if (REPEAT) begin
            rn = (line_buf.size() < ML) ? line_buf.size() : ML;
            for (int i = 0; i < rn; i++) begin
              nb = {line_buf[i], 1'b0, 1'b0};       exp_q.push_back(nb);
              nb = {line_buf[i], (i == rn - 1), 1'b0}; exp_q.push_back(nb);
            end
          end
          line_buf.delete();
        end
      end
    end
    rst_prev = rst;
  end

  initial begin
    down_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      down_ready = stall_en ? ($urandom_range(0, 1) == 1) : ready_force;
    end
  end

  task automatic send_px(input logic [DW-1:0] d, input logic l, input logic u);
    int c = 0;
    bit done = 0;
    up_data = d; up_tlast = l; up_tuser = u; up_valid = 1'b1;
    while (!done && c < 400) begin
      @(negedge clk);
      if (up_ready) done = 1;
      @(posedge clk); #1;
      c++;
    end
    up_valid = 1'b0; up_tlast = 1'b0; up_tuser = 1'b0;
    if (!done) chk("send_timeout", 32'(done), 1);
  endtask

  task automatic send_line(input int n, input logic [DW-1:0] base, input logic sof);
    for (int i = 0; i < n; i++)
      send_px(base + DW'(i), (i == n - 1), sof && (i == 0));
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while (exp_q.size() != 0 && c < maxc) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain_left", 32'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string nm, input int idx, input logic [DW-1:0] d,
                          input logic l, input logic u);
    if (idx < log_q.size()) begin
      chk({nm, "_d"}, 32'(log_q[idx].d), 32'(d));
      chk({nm, "_l"}, 32'(log_q[idx].l), 32'(l));
      chk({nm, "_u"}, 32'(log_q[idx].u), 32'(u));
    end else begin
      chk({nm, "_present"}, 32'(log_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int c;
    rst = 1'b1; up_valid = 1'b0; up_data = '0; up_tlast = 1'b0; up_tuser = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single 3-pixel line A1,B2,C3
    log_q.delete();
    send_px(8'hA1, 1'b0, 1'b1);
    send_px(8'hB2, 1'b0, 1'b0);
    send_px(8'hC3, 1'b1, 1'b0);
    drain(200);
    chk("t1_count", 32'(log_q.size()), REPEAT ? 12 : 6);
    chk_beat("t1_b0", 0, 8'hA1, 1'b0, 1'b1);
    chk_beat("t1_b1", 1, 8'hA1, 1'b0, 1'b0);
    chk_beat("t1_b5", 5, 8'hC3, 1'b1, 1'b0);
    if (REPEAT) begin
      chk_beat("t1_b6", 6, 8'hA1, 1'b0, 1'b0);
      chk_beat("t1_b11", 11, 8'hC3, 1'b1, 1'b0);
    end

    // Two 4-pixel lines back to back
    log_q.delete();
    send_line(4, 8'h10, 1'b1);
    send_line(4, 8'h20, 1'b0);
    drain(300);
    chk("t2_count", 32'(log_q.size()), REPEAT ? 32 : 16);
    chk_beat("t2_b8", 8, REPEAT ? 8'h10 : 8'h20, 1'b0, 1'b0);

    // 8x4 frame with random downstream stalls
    log_q.delete();
    stall_en = 1'b1;
    for (int r = 0; r < 4; r++) send_line(8, DW'(r * 16), (r == 0));
    drain(2000);
    stall_en = 1'b0;
    chk("t3_count", 32'(log_q.size()), REPEAT ? 96 : 64);

    // Line longer than the buffer
    log_q.delete();
    send_line(6, 8'h30, 1'b1);
    drain(300);
    chk("t4_count", 32'(log_q.size()), REPEAT ? 20 : 12);
    chk_beat("t4_b11", 11, 8'h35, 1'b1, 1'b0);
    if (REPEAT) chk_beat("t4_b19", 19, 8'h33, 1'b1, 1'b0);

    // Reset in the middle of a replay, then a fresh 2-pixel line
    send_line(4, 8'h40, 1'b1);
    c = 0;
    while (tl_out < 1 && c < 100) begin @(posedge clk); #1; c++; end
    chk("t5_pass_done", 32'(tl_out >= 1), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    log_q.delete();
    send_px(8'h5A, 1'b0, 1'b1);
    send_px(8'h6B, 1'b1, 1'b0);
    drain(200);
    chk("t5_count", 32'(log_q.size()), REPEAT ? 8 : 4);
    chk_beat("t5_b0", 0, 8'h5A, 1'b0, 1'b1);
    chk_beat("t5_b3", 3, 8'h6B, 1'b1, 1'b0);
    if (REPEAT) begin
      chk_beat("t5_b4", 4, 8'h5A, 1'b0, 1'b0);
      chk_beat("t5_b7", 7, 8'h6B, 1'b1, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
